tissue_loader: RTL

Upstream sequencer for `tissue`. Accepts the initial cell pattern one row at a time over a valid/ready handshake and buffers the whole frame. It then streams the frame bit-serially into the tissue's `init`/`cell_init_status_in` inputs, issues the one-cycle start pulse on the tissue's `rst` input, and waits for `done`. It reports completion and, optionally, the run length in cycles.

---
 rtl/tissue_loader_if.sv | 12 +
 rtl/tissue_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tissue_loader_if.sv
// Row-load handshake between a row source and tissue_loader.
// master: drives rows; slave: the loader, which returns row_ready.
interface tissue_loader_if #(
   parameter int WIDTH = 30
) ();
   logic [WIDTH-1:0] row_in;
   logic             row_valid;
   logic             row_ready;

   modport master (output row_in, output row_valid, input row_ready);
   modport slave  (input row_in, input row_valid, output row_ready);
endinterface

// File: rtl/tissue_loader.sv
// tissue_loader: buffers one frame of rows, streams it bit-serially into the
// tissue, kicks it with a one-cycle rst pulse and waits for its done edge.
// Optional feature macro: TISSUE_LOADER_RUN_TIMER_EN (RUN cycle counter,
// run_cycles report and MAX_RUN_CYCLES timeout).
module tissue_loader #(
   parameter int          TISSUE_WIDTH   = 30,
   parameter int          TISSUE_HEIGHT  = 3,
   parameter logic [31:0] MAX_RUN_CYCLES = 32'd1048576
) (
   input  logic                clk,
   input  logic                rst_n,
   tissue_loader_if.slave      row,
   output logic                tissue_init,
   output logic                tissue_cell_status,
   output logic                tissue_rst,
   input  logic                tissue_done,
   output logic                busy,
   output logic                run_done,
   output logic                run_timeout,
   output logic [31:0]         run_cycles
);
   localparam int XW = (TISSUE_WIDTH  > 1) ? $clog2(TISSUE_WIDTH)  : 1;
   localparam int YW = (TISSUE_HEIGHT > 1) ? $clog2(TISSUE_HEIGHT) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, KICK, RUN} state_t;

   state_t state;
   logic [TISSUE_HEIGHT-1:0][TISSUE_WIDTH-1:0] frame;
   logic [YW-1:0] row_cnt;
   logic [XW-1:0] x, nx;
   logic [YW-1:0] y, ny;
   logic done_q, done_rise, accept, last_row, last_bit, first_bit;
`ifdef TISSUE_LOADER_RUN_TIMER_EN
   logic [31:0] cnt;
`endif

   assign row.row_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign accept        = row.row_valid & row.row_ready;
   assign last_row      = (row_cnt == YW'(TISSUE_HEIGHT - 1));
   assign last_bit      = (x == XW'(TISSUE_WIDTH - 1)) && (y == YW'(TISSUE_HEIGHT - 1));
   assign done_rise     = tissue_done & ~done_q;
   // With a single-row frame, bit 0 arrives on the same edge that enters STREAM.
   assign first_bit     = (TISSUE_HEIGHT == 1) ? row.row_in[0] : frame[0][0];

   // Next stream position: row-major, bit 0 of each row first.
   always_comb begin
      nx = x + XW'(1);
      ny = y;
      if (x == XW'(TISSUE_WIDTH - 1)) begin
         nx = '0;
         ny = y + YW'(1);
      end
   end

   // Control FSM with registered tissue-side outputs and run reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         frame              <= '0;
         row_cnt            <= '0;
         x                  <= '0;
         y                  <= '0;
         tissue_init        <= 1'b0;
         tissue_cell_status <= 1'b0;
         tissue_rst         <= 1'b0;
         run_done           <= 1'b0;
         done_q             <= 1'b0;
`ifdef TISSUE_LOADER_RUN_TIMER_EN
         cnt                <= '0;
         run_cycles         <= '0;
         run_timeout        <= 1'b0;
`endif
      end else begin
         done_q   <= tissue_done;
         run_done <= 1'b0;
`ifdef TISSUE_LOADER_RUN_TIMER_EN
         run_timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  frame[row_cnt] <= row.row_in;
                  row_cnt        <= row_cnt + YW'(1);
                  if (last_row) begin
                     state              <= STREAM;
                     x                  <= '0;
                     y                  <= '0;
                     tissue_init        <= 1'b1;
                     tissue_cell_status <= first_bit;
                  end
               end
            end
            STREAM: begin
               if (last_bit) begin
                  state              <= KICK;
                  tissue_init        <= 1'b0;
                  tissue_cell_status <= 1'b0;
                  tissue_rst         <= 1'b1;
               end else begin
                  x                  <= nx;
                  y                  <= ny;
                  tissue_cell_status <= frame[ny][nx];
               end
            end
            KICK: begin
               tissue_rst <= 1'b0;
               state      <= RUN;
`ifdef TISSUE_LOADER_RUN_TIMER_EN
               cnt        <= 32'd1;
`endif
            end
            RUN: begin
               // Only a fresh rising edge ends the run; a stale done level is ignored.
               if (done_rise) begin
                  run_done <= 1'b1;
                  row_cnt  <= '0;
                  state    <= IDLE;
`ifdef TISSUE_LOADER_RUN_TIMER_EN
                  run_cycles <= cnt;
`endif
               end
`ifdef TISSUE_LOADER_RUN_TIMER_EN
               else if (cnt == MAX_RUN_CYCLES) begin
                  run_done    <= 1'b1;
                  run_timeout <= 1'b1;
                  run_cycles  <= MAX_RUN_CYCLES;
                  row_cnt     <= '0;
                  state       <= IDLE;
               end else if (cnt != '1) begin
                  cnt <= cnt + 32'd1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef TISSUE_LOADER_RUN_TIMER_EN
   assign run_cycles  = '0;
   assign run_timeout = 1'b0;
`endif
endmodule
